cpu_regfile: RTL and testbench
==============================

Name: cpu_regfile

Overview:
- Responder for the register-read / IP-update interface driven by the ISA execution units.
- Holds the general-purpose register bank and the instruction pointer (IP).
- Serves `reg_id`/`reg_re` reads with a value that is valid in the same cycle and held after the read ends, accepts register writes, and applies `ip_set`/`ip_val` jumps and sequential IP increments.
- Sits between the instruction sequencer/executors and the ALU data path.

Parameters:
- `NREGS`, 16, number of implemented registers (1..16); ids >= `NREGS` are unimplemented.
- `ZERO_R0`, 0, when 1, register 0 always reads 0 and writes to it are discarded.
- `RESET_IP`, 0, IP value after reset.
- `IP_STEP`, 8, amount added to IP on `ip_inc`.

Ports:
- `clk`  in  1  system clock, all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `reg_id`  in  4  register selected for read.
- `reg_re`  in  1  read enable.
- `reg_out`  out  64  read data.
- `reg_we`  in  1  write enable.
- `reg_wid`  in  4  register selected for write.
- `reg_in`  in  64  write data.
- `ip_set`  in  1  load IP from `ip_val`.
- `ip_val`  in  64  jump target.
- `ip_inc`  in  1  advance IP by `IP_STEP`.
- `ip`  out  64  current instruction pointer.

Behaviour:
- Reset (`rst_n`=0, asynchronous, any time):
  - all registers <= 0; held read latch <= 0; `ip` <= `RESET_IP`.
  - Outputs: `reg_out`=0 while `reg_re`=0; `ip`=`RESET_IP`.
  - Release is synchronous to the next `clk` rising edge; no operation is lost or replayed.
- Read port:
  - Combinational while `reg_re`=1: `reg_out` = contents of `reg_id` (0 if `reg_id` >= `NREGS`, or `reg_id`=0 with `ZERO_R0`=1).
  - Latency 0: an executor that registers `reg_id`/`reg_re` on edge k samples valid data on edge k+1.
  - Hold latch: on every rising edge with `reg_re`=1, the latch captures the value currently shown on `reg_out`.
  - While `reg_re`=0, `reg_out` = latch, unchanged until the next sampled read. This lets an executor drop `reg_re` and still feed the ALU with the last-read operand.
  - `reg_id` changes while `reg_re`=1 are followed combinationally; the latch takes whatever is selected at the edge.
- Write port:
  - On rising edge with `reg_we`=1, register `reg_wid` <= `reg_in`.
  - Ignored if `reg_wid` >= `NREGS`, or `reg_wid`=0 with `ZERO_R0`=1.
- Read/write same register in the same cycle:
  - `reg_out` shows the OLD value until the edge; the latch captures the OLD value.
  - The new value is visible from the cycle after the edge.
  - No write-to-read bypass.
- Hold-latch coherency: a write to the register last latched does NOT update the latch; `reg_out` with `reg_re`=0 keeps the stale value by design.
- IP, evaluated on each rising edge in this priority:
  - `ip_set`=1: `ip` <= `ip_val`, and any `ip_inc` in the same cycle is dropped.
  - else `ip_inc`=1: `ip` <= `ip` + `IP_STEP`, modulo 2^64 (wraps to low bits, no flag).
  - else `ip` holds.
- `ip_set` held high for several cycles reloads `ip_val` every cycle (idempotent if `ip_val` is stable).
- Simultaneous read, write and IP update are independent and all take effect in the same cycle.

Test Plan:
- Reset then `reg_re`=1, `reg_id`=3 -> `reg_out`=0; `ip`=`RESET_IP` (0).
- Write r5=0x1122334455667788 (`reg_we` one cycle); next cycle `reg_re`=1, `reg_id`=5 -> `reg_out`=0x1122334455667788 same cycle. Drop `reg_re`, then write r5=0xFF -> `reg_out` stays 0x1122334455667788.
- Branch-style sequence:
  - Edge k: `reg_id`=1 (r1=10), `reg_re`=1.
  - Edge k+1: `reg_id`=2 (r2=20).
  - Edge k+2: `reg_re`=0.
  - Expected `reg_out`: 10 during cycle k..k+1, 20 during k+1..k+2, and 20 held afterwards.
- Same-cycle `reg_we` r7<=9 and read r7 (old 4) -> `reg_out`=4 that cycle, latch=4; read r7 next cycle -> 9.
- `ip`=0x10, `ip_inc`=1 for 3 cycles -> 0x28. Then `ip_set`=1, `ip_val`=0x400 with `ip_inc`=1 -> 0x400, not 0x408. `ip`=0xFFFFFFFFFFFFFFF8 plus `ip_inc` -> 0.
- `ZERO_R0`=1: write r0=0xAB, read r0 -> 0. `NREGS`=8: write r12=5, read r12 -> 0. Assert `rst_n` mid-read -> `reg_out`=0 immediately when `reg_re` is low.

Source files
------------

// File: rtl/cpu_regfile.sv
// cpu_regfile: general-purpose register bank plus instruction pointer.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   reg_id, reg_re    read select / enable; reg_out follows reg_id while
//                     reg_re=1 and holds the last sampled read otherwise
//   reg_out           read data (combinational read mux / hold latch)
//   reg_we, reg_wid,  write enable, write select, write data
//   reg_in
//   ip_set, ip_val    load IP with a jump target (wins over ip_inc)
//   ip_inc            advance IP by IP_STEP (wraps modulo 2^64)
//   ip                current instruction pointer (registered)
module cpu_regfile #(
  parameter int unsigned NREGS    = 16,
  parameter bit          ZERO_R0  = 1'b0,
  parameter logic [63:0] RESET_IP = 64'd0,
  parameter logic [63:0] IP_STEP  = 64'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  reg_id,
  input  logic        reg_re,
  output logic [63:0] reg_out,
  input  logic        reg_we,
  input  logic [3:0]  reg_wid,
  input  logic [63:0] reg_in,
  input  logic        ip_set,
  input  logic [63:0] ip_val,
  input  logic        ip_inc,
  output logic [63:0] ip
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned NSLOTS = 16;

  logic [DATA_W-1:0] regs [NSLOTS];
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] rd_val_c;
  logic              rd_hit_c;
  logic              wr_hit_c;

  // An id addresses storage only if implemented and not the hardwired zero.
  always_comb begin
    rd_hit_c = (32'(reg_id) < NREGS) && !(ZERO_R0 && (reg_id == ID_W'(0)));
    wr_hit_c = reg_we && (32'(reg_wid) < NREGS)
               && !(ZERO_R0 && (reg_wid == ID_W'(0)));
    rd_val_c = rd_hit_c ? regs[reg_id] : '0;
  end

  // Live read while enabled, otherwise the last sampled operand.
  assign reg_out = reg_re ? rd_val_c : hold_q;

  // Register bank; slots beyond NREGS stay at their reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSLOTS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NSLOTS); i++) begin
        if (wr_hit_c && (reg_wid == ID_W'(i))) begin
          regs[i] <= reg_in;
        end
      end
    end
  end

  // Hold latch captures the pre-write value shown on reg_out; writes never
  // refresh it, so a stale operand is kept on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (reg_re) begin
      hold_q <= rd_val_c;
    end
  end

  // Instruction pointer: jump has priority over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip <= RESET_IP;
    end else if (ip_set) begin
      ip <= ip_val;
    end else if (ip_inc) begin
      ip <= ip + IP_STEP;
    end
  end

endmodule

// File: tb/tb_cpu_regfile.sv
// Bench for cpu_regfile: two instances (default config and an 8-register,
// zero-r0 config) share one stimulus stream and are checked against a
// behavioural model every cycle, plus directed literal expectations.
module tb_cpu_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  reg_id;
  logic        reg_re;
  logic        reg_we;
  logic [3:0]  reg_wid;
  logic [63:0] reg_in;
  logic        ip_set;
  logic [63:0] ip_val;
  logic        ip_inc;
  logic [63:0] out_a, out_b, ip_a, ip_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_regfile dut_a (
    .clk(clk), .rst_n(rst_n), .reg_id(reg_id), .reg_re(reg_re), .reg_out(out_a),
    .reg_we(reg_we), .reg_wid(reg_wid), .reg_in(reg_in), .ip_set(ip_set),
    .ip_val(ip_val), .ip_inc(ip_inc), .ip(ip_a)
  );

  cpu_regfile #(.NREGS(8), .ZERO_R0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .reg_id(reg_id), .reg_re(reg_re), .reg_out(out_b),
    .reg_we(reg_we), .reg_wid(reg_wid), .reg_in(reg_in), .ip_set(ip_set),
    .ip_val(ip_val), .ip_inc(ip_inc), .ip(ip_b)
  );

  // ---------------- behavioural model ----------------
  // Index 0 models dut_a (16 regs, r0 writable), index 1 models dut_b.
  logic [63:0] m_regs [2][16];
  logic [63:0] m_hold [2];
  logic [63:0] m_ip;

  function automatic bit m_valid(int c, logic [3:0] id);
    int nregs;
    nregs = (c == 0) ? 16 : 8;
    if (int'(id) >= nregs) return 1'b0;
    if (c == 1 && id == 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] m_view(int c, logic [3:0] id);
    return m_valid(c, id) ? m_regs[c][id] : 64'd0;
  endfunction

  function automatic logic [63:0] m_out(int c);
    return reg_re ? m_view(c, reg_id) : m_hold[c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 16; i++) m_regs[c][i] = 64'd0;
        m_hold[c] = 64'd0;
      end
      m_ip = 64'd0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (reg_re) m_hold[c] = m_view(c, reg_id);
        if (reg_we && m_valid(c, reg_wid)) m_regs[c][reg_wid] = reg_in;
      end
      if (ip_set)      m_ip = ip_val;
      else if (ip_inc) m_ip = m_ip + 64'd8;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_out_a", out_a, m_out(0));
    chk("model_out_b", out_b, m_out(1));
    chk("model_ip_a", ip_a, m_ip);
    chk("model_ip_b", ip_b, m_ip);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] id, input logic [63:0] d);
    reg_we = 1'b1; reg_wid = id; reg_in = d;
    step();
    reg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reg_id = '0; reg_re = 1'b0; reg_we = 1'b0; reg_wid = '0;
    reg_in = '0; ip_set = 1'b0; ip_val = '0; ip_inc = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    reg_re = 1'b1; reg_id = 4'd3;
    #1;
    chk("reset_read_r3", out_a, 64'd0);
    chk("reset_ip", ip_a, 64'd0);
    step();

    // Write then same-cycle read, then stale hold after rewrite
    reg_re = 1'b0;
    wr(4'd5, 64'h1122334455667788);
    reg_re = 1'b1; reg_id = 4'd5;
    #1;
    chk("read_r5", out_a, 64'h1122334455667788);
    step();
    reg_re = 1'b0;
    wr(4'd5, 64'hFF);
    chk("hold_stale_r5", out_a, 64'h1122334455667788);

    // Branch-style sequence
    wr(4'd1, 64'd10);
    wr(4'd2, 64'd20);
    reg_re = 1'b1; reg_id = 4'd1;
    #1;
    chk("branch_r1", out_a, 64'd10);
    step();
    reg_id = 4'd2;
    #1;
    chk("branch_r2", out_a, 64'd20);
    step();
    reg_re = 1'b0;
    #1;
    chk("branch_hold0", out_a, 64'd20);
    step();
    chk("branch_hold1", out_a, 64'd20);

    // Same-cycle read/write of r7: old value shown and latched
    wr(4'd7, 64'd4);
    reg_re = 1'b1; reg_id = 4'd7;
    reg_we = 1'b1; reg_wid = 4'd7; reg_in = 64'd9;
    #1;
    chk("rw_same_old", out_a, 64'd4);
    step();
    reg_we = 1'b0; reg_re = 1'b0;
    #1;
    chk("rw_latch_old", out_a, 64'd4);
    reg_re = 1'b1;
    #1;
    chk("rw_new_visible", out_a, 64'd9);
    step();
    reg_re = 1'b0;

    // IP sequencing, priority and wrap
    ip_set = 1'b1; ip_val = 64'h10;
    step();
    chk("ip_load", ip_a, 64'h10);
    ip_set = 1'b0; ip_inc = 1'b1;
    step(); step(); step();
    chk("ip_inc3", ip_a, 64'h28);
    ip_set = 1'b1; ip_val = 64'h400;
    step();
    chk("ip_set_beats_inc", ip_a, 64'h400);
    step();
    chk("ip_set_held", ip_a, 64'h400);
    ip_inc = 1'b0; ip_val = 64'hFFFFFFFFFFFFFFF8;
    step();
    ip_set = 1'b0; ip_inc = 1'b1;
    step();
    chk("ip_wrap", ip_a, 64'd0);
    ip_inc = 1'b0;

    // Hardwired r0 and unimplemented ids (dut_b), normal in dut_a
    wr(4'd0, 64'hAB);
    wr(4'd12, 64'd5);
    reg_re = 1'b1; reg_id = 4'd0;
    #1;
    chk("r0_a", out_a, 64'hAB);
    chk("r0_zero_b", out_b, 64'd0);
    reg_id = 4'd12;
    #1;
    chk("r12_a", out_a, 64'd5);
    chk("r12_unimpl_b", out_b, 64'd0);
    reg_id = 4'd5;
    #1;
    chk("r5_b", out_b, 64'hFF);
    step();

    // Asynchronous reset while holding a nonzero operand
    reg_re = 1'b0;
    ip_set = 1'b1; ip_val = 64'h1234;
    step();
    ip_set = 1'b0;
    chk("pre_reset_hold", out_a, 64'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_a", out_a, 64'd0);
    chk("async_rst_out_b", out_b, 64'd0);
    chk("async_rst_ip", ip_a, 64'd0);
    step();
    rst_n = 1'b1;
    reg_re = 1'b1; reg_id = 4'd5;
    #1;
    chk("post_reset_r5", out_a, 64'd0);
    step();
    reg_re = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
